// File: rtl/eclair_mem_pkg.sv
// Shared definitions for the boot-memory path: fetch FSM states, EPROM geometry
// and the default access wait-state count also used by the EPROM model and image tooling.
package eclair_mem_pkg;

  localparam int ROM_ADDR_W      = 20;
  localparam int ROM_DATA_W      = 8;
  localparam int ROM_WAIT_CYCLES = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } fetch_state_e;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    while ((1 << w) <= max_val) w++;
    return w;
  endfunction

endpackage

// File: rtl/boot_rom_fetch_if.sv
// Core-side request/response channels of the boot ROM fetch controller.
interface boot_rom_fetch_if
  import eclair_mem_pkg::*;
#(
  parameter int ADDR_W     = ROM_ADDR_W,
  parameter int WORD_BYTES = 2
);

  logic                           req_valid;
  logic                           req_ready;
  logic [ADDR_W-1:0]              req_addr;
  logic                           abort;
  logic                           rsp_valid;
  logic                           rsp_ready;
  logic [ROM_DATA_W*WORD_BYTES-1:0] rsp_data;

  modport master (
    output req_valid, req_addr, abort, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_addr, abort, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/rom_wait_timer.sv
// Loadable wait-state down-counter; holds at zero and flags it. Shared by the
// memory-side controllers that need programmable access windows.
module rom_wait_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/boot_rom_fetch.sv
// Boot EPROM fetch controller: sequences _cs/_oe/addr with wait-states and
// assembles consecutive bytes big-endian into one response word.
//
//   state  | meaning
//   IDLE   | ready for a request, EPROM deselected
//   SETUP  | one cycle of address setup before _cs/_oe drop
//   ACCESS | _cs/_oe low; byte sampled when the wait timer reaches zero
//   RESP   | word held on rsp_data until the core takes it
module boot_rom_fetch
  import eclair_mem_pkg::*;
#(
  parameter int ADDR_W      = ROM_ADDR_W,
  parameter int WORD_BYTES  = 2,
  parameter int WAIT_CYCLES = ROM_WAIT_CYCLES
) (
  input  logic                  clk,
  input  logic                  _reset,
  boot_rom_fetch_if.slave       bus,
  output logic                  _rom_cs,
  output logic                  _rom_oe,
  output logic [ADDR_W-1:0]     rom_addr,
  input  logic [ROM_DATA_W-1:0] rom_data
);

  localparam int WORD_W = ROM_DATA_W * WORD_BYTES;
  localparam int IDX_W  = cnt_width(WORD_BYTES - 1);
  localparam int CNT_W  = cnt_width(WAIT_CYCLES - 1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
  logic [WORD_W-1:0] asm_q, asm_d;
  logic [WORD_W-1:0] rsp_data_q, rsp_data_d;
  logic [WORD_W-1:0] word_cap;
  logic              last_byte;
  logic              tmr_load;
  logic              tmr_en;
  logic              tmr_zero;

  rom_wait_timer #(
    .CNT_W (CNT_W)
  ) u_wait_timer (
    .clk      (clk),
    .rst_n    (_reset),
    .load     (tmr_load),
    .load_val (CNT_W'(WAIT_CYCLES - 1)),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  assign last_byte = (byte_idx_q == IDX_W'(WORD_BYTES - 1));

  // Bytes build up in asm_q so an aborted fetch never disturbs rsp_data.
  always_comb begin
    word_cap = asm_q;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (byte_idx_q == IDX_W'(WORD_BYTES - 1 - i)) begin
        word_cap[ROM_DATA_W*i +: ROM_DATA_W] = rom_data;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    rsp_data_d = rsp_data_q;
    tmr_load   = 1'b0;
    tmr_en     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          rom_addr_d = bus.req_addr;
          byte_idx_d = '0;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          tmr_load = 1'b1;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (!tmr_zero) begin
          tmr_en = 1'b1;
        end else if (last_byte) begin
          rsp_data_d = word_cap;
          state_d    = RESP;
        end else begin
          asm_d      = word_cap;
          byte_idx_d = byte_idx_q + IDX_W'(1);
          rom_addr_d = rom_addr_q + ADDR_W'(1);
          tmr_load   = 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state_q    <= IDLE;
      rom_addr_q <= '0;
      byte_idx_q <= '0;
      asm_q      <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign _rom_cs       = (state_q != ACCESS);
  assign _rom_oe       = (state_q != ACCESS);
  assign rom_addr      = rom_addr_q;
  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_boot_rom_fetch.sv
// Self-checking bench for boot_rom_fetch: directed vector table, corner sequences
// and randomized fetches against a transaction-level EPROM reference.
module tb_boot_rom_fetch;

  localparam int AW    = 20;
  localparam int WB    = 2;
  localparam int WAITC = 3;
  localparam int LAT   = 1 + WAITC * WB;
  localparam logic [AW-1:0] AMASK = '1;

  logic          clk;
  logic          reset_b;
  logic          rom_cs_b;
  logic          rom_oe_b;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic [7:0]    rom_mem [0:1048575];

  int n_pass;
  int n_tot;
  logic [15:0] last_data;

  boot_rom_fetch_if #(.ADDR_W(AW), .WORD_BYTES(WB)) bif ();

  boot_rom_fetch #(
    .ADDR_W      (AW),
    .WORD_BYTES  (WB),
    .WAIT_CYCLES (WAITC)
  ) dut (
    .clk      (clk),
    ._reset   (reset_b),
    .bus      (bif),
    ._rom_cs  (rom_cs_b),
    ._rom_oe  (rom_oe_b),
    .rom_addr (rom_addr),
    .rom_data (rom_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ECL EPROM: drives zeros whenever it is not selected and enabled
  always_comb rom_data = (!rom_cs_b && !rom_oe_b) ? rom_mem[rom_addr] : 8'h00;

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   exp;
    int            abort_at;
    int            hold;
  } vec_t;

  vec_t vecs [7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_word(input logic [AW-1:0] a);
    logic [15:0] w;
    w = '0;
    for (int i = 0; i < WB; i++) begin
      w = {w[7:0], rom_mem[(a + AW'(i)) & AMASK]};
    end
    return w;
  endfunction

  // Issue one request from IDLE; abort_at < 0 means run to completion.
  task automatic run_fetch(input logic [AW-1:0] a, input logic [15:0] exp,
                           input int abort_at, input int hold, input string tag);
    int   c;
    int   lat;
    int   cs_cnt;
    logic addr_ok;
    logic pins_ok;
    logic bp_ok;
    logic [AW-1:0] exp_a;
    check({tag, "_idle_ready"}, 32'(bif.req_ready), 32'd1);
    bif.req_valid = 1'b1;
    bif.req_addr  = a;
    step();
    bif.req_valid = 1'b0;
    bif.req_addr  = a ^ 20'h5A5A5;
    lat = -1; cs_cnt = 0; addr_ok = 1'b1; pins_ok = 1'b1;
    for (c = 0; c <= 40; c++) begin
      if (bif.rsp_valid) begin
        lat = c;
        break;
      end
      if (rom_cs_b !== rom_oe_b) pins_ok = 1'b0;
      if (!rom_cs_b) begin
        exp_a = (a + AW'(cs_cnt / WAITC)) & AMASK;
        if (rom_addr !== exp_a) addr_ok = 1'b0;
        cs_cnt++;
      end
      if (c == abort_at) begin
        bif.abort = 1'b1;
        step();
        bif.abort = 1'b0;
        check({tag, "_abort_cs"}, 32'({rom_cs_b, rom_oe_b}), 32'b11);
        check({tag, "_abort_ready"}, 32'(bif.req_ready), 32'd1);
        check({tag, "_abort_data"}, 32'(bif.rsp_data), 32'(last_data));
        step();
        step();
        check({tag, "_abort_no_rsp"}, 32'(bif.rsp_valid), 32'd0);
        return;
      end
      step();
    end
    if (lat < 0) begin
      $display("FAIL %s_timeout: got no rsp_valid within 40 cycles expected %0d", tag, LAT);
      n_tot++;
      return;
    end
    check({tag, "_latency"}, 32'(lat), 32'(LAT));
    check({tag, "_cs_cycles"}, 32'(cs_cnt), 32'(WAITC * WB));
    check({tag, "_addr_seq"}, 32'(addr_ok && pins_ok), 32'd1);
    check({tag, "_data"}, 32'(bif.rsp_data), 32'(exp));
    if (hold > 0) begin
      bp_ok = 1'b1;
      for (int h = 0; h < hold; h++) begin
        bif.req_valid = 1'b1;
        step();
        if (!bif.rsp_valid || bif.rsp_data !== exp || bif.req_ready ||
            !rom_cs_b || !rom_oe_b) bp_ok = 1'b0;
      end
      bif.req_valid = 1'b0;
      check({tag, "_bp_stable"}, 32'(bp_ok), 32'd1);
    end
    bif.rsp_ready = 1'b1;
    step();
    bif.rsp_ready = 1'b0;
    check({tag, "_release"}, 32'({bif.req_ready, bif.rsp_valid}), 32'b10);
    last_data = exp;
  endtask

  initial begin
    int n_acc;
    int n_rsp;
    int acc_cyc [4];
    int rsp_cyc [4];
    logic [15:0] rsp_dat [4];
    logic prev_v;
    logic acc_now;
    logic [AW-1:0] ra;
    n_pass = 0;
    n_tot  = 0;
    last_data = '0;
    reset_b = 1'b1;
    bif.req_valid = 1'b0;
    bif.req_addr  = '0;
    bif.abort     = 1'b0;
    bif.rsp_ready = 1'b0;

    for (int i = 0; i < 1048576; i++) rom_mem[i] = 8'($urandom);
    rom_mem[20'h00010] = 8'hA5;
    rom_mem[20'h00011] = 8'h3C;
    rom_mem[20'hFFFFF] = 8'h12;
    rom_mem[20'h00000] = 8'h34;
    rom_mem[20'h00001] = 8'h56;
    rom_mem[20'h00002] = 8'h78;
    rom_mem[20'h00003] = 8'h9A;

    vecs[0] = '{addr: 20'h00010, exp: 16'hA53C, abort_at: -1, hold: 0};
    vecs[1] = '{addr: 20'hFFFFF, exp: 16'h1234, abort_at: -1, hold: 0};
    vecs[2] = '{addr: 20'h00010, exp: 16'hA53C, abort_at: -1, hold: 5};
    vecs[3] = '{addr: 20'h00010, exp: 16'h0000, abort_at: 5,  hold: 0};
    vecs[4] = '{addr: 20'h00010, exp: 16'hA53C, abort_at: -1, hold: 0};
    vecs[5] = '{addr: 20'h00000, exp: 16'h0000, abort_at: 6,  hold: 0};
    vecs[6] = '{addr: 20'h00002, exp: 16'h789A, abort_at: -1, hold: 2};

    #2 reset_b = 1'b0;
    #2;
    check("rst_req_ready", 32'(bif.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bif.rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(bif.rsp_data), 32'd0);
    check("rst_cs_oe", 32'({rom_cs_b, rom_oe_b}), 32'b11);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    step();
    step();
    #2 reset_b = 1'b1;
    step();

    for (int v = 0; v < 7; v++) begin
      run_fetch(vecs[v].addr, vecs[v].exp, vecs[v].abort_at, vecs[v].hold, $sformatf("vec%0d", v));
      step();
    end

    // Reset in the middle of an access window
    bif.req_valid = 1'b1;
    bif.req_addr  = 20'h00010;
    step();
    bif.req_valid = 1'b0;
    step();
    step();
    step();
    check("mid_rst_in_access", 32'(rom_cs_b), 32'd0);
    #2 reset_b = 1'b0;
    #1;
    check("mid_rst_cs_oe", 32'({rom_cs_b, rom_oe_b}), 32'b11);
    check("mid_rst_ready", 32'(bif.req_ready), 32'd1);
    check("mid_rst_rsp", 32'({bif.rsp_valid, bif.rsp_data}), 32'd0);
    last_data = '0;
    step();
    #2 reset_b = 1'b1;
    step();
    run_fetch(20'h00010, 16'hA53C, -1, 0, "post_rst");

    // Back-to-back with req_valid and rsp_ready held high
    n_acc = 0; n_rsp = 0; prev_v = 1'b0;
    bif.req_addr  = 20'h00000;
    bif.req_valid = 1'b1;
    bif.rsp_ready = 1'b1;
    for (int c = 0; c < 26; c++) begin
      if (bif.rsp_valid && !prev_v && n_rsp < 4) begin
        rsp_cyc[n_rsp] = c;
        rsp_dat[n_rsp] = bif.rsp_data;
        n_rsp++;
      end
      prev_v  = bif.rsp_valid;
      acc_now = bif.req_valid && bif.req_ready;
      if (acc_now && n_acc < 4) acc_cyc[n_acc] = c;
      step();
      if (acc_now) begin
        n_acc++;
        if (n_acc == 1) bif.req_addr = 20'h00002;
        else bif.req_valid = 1'b0;
      end
    end
    bif.rsp_ready = 1'b0;
    check("b2b_accepts", 32'(n_acc), 32'd2);
    check("b2b_responses", 32'(n_rsp), 32'd2);
    if (n_acc == 2 && n_rsp == 2) begin
      check("b2b_rsp_gap", 32'(rsp_cyc[1] - rsp_cyc[0]), 32'd9);
      check("b2b_acc_gap", 32'(acc_cyc[1] - acc_cyc[0]), 32'd9);
      check("b2b_first_lat", 32'(rsp_cyc[0] - acc_cyc[0]), 32'(LAT + 1));
      check("b2b_data0", 32'(rsp_dat[0]), 32'h3456);
      check("b2b_data1", 32'(rsp_dat[1]), 32'h789A);
      last_data = 16'h789A;
    end
    step();

    // Randomized fetches, including wrap-around addresses and random aborts
    for (int r = 0; r < 40; r++) begin
      int ab;
      if ($urandom_range(0, 3) == 0) ra = AMASK - AW'($urandom_range(0, 2));
      else ra = AW'($urandom);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, LAT - 1)) : -1;
      run_fetch(ra, model_word(ra), ab, int'($urandom_range(0, 3)), $sformatf("rnd%0d", r));
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
